// File: rtl/pjdl_pkg.sv
// pjdl_pkg: shared types for the PJDL transmit midend (request/stream structs, FSM states). Rev 1.0
`default_nettype none
package pjdl_pkg;

  localparam int unsigned PjdlChunkBytes = 4;

  typedef enum logic [1:0] {
    AXI        = 2'd0,
    OBI        = 2'd1,
    AXI_STREAM = 2'd2
  } protocol_e;

  typedef struct packed {
    protocol_e src_protocol;
    protocol_e dst_protocol;
  } idma_opt_t;

  typedef struct packed {
    logic [31:0] length;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    idma_opt_t   opt;
  } idma_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axis_beat_t;

  typedef struct packed {
    axis_beat_t t;
    logic       tvalid;
  } axis_large_req_t;

  typedef struct packed {
    logic tready;
  } axis_large_rsp_t;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    P_ISSUE = 3'd3,
    P_WAIT  = 3'd4,
    RESP    = 3'd5
  } pjdl_tx_midend_state_e;

  function automatic logic [31:0] chunk_len(input logic [31:0] len, input logic [31:0] chunk);
    return (len > chunk) ? chunk : len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pjdl_idma_tx_midend_if.sv
// pjdl_idma_tx_midend_if: frontend, backend and stream handshakes of the PJDL TX midend. Rev 1.0
`default_nettype none
interface pjdl_idma_tx_midend_if;
  import pjdl_pkg::*;

  idma_req_t       frontend_idma_req_i;
  logic            frontend_idma_req_valid_i;
  logic            frontend_idma_req_ready_o;
  logic            frontend_idma_rsp_valid_o;
  logic            frontend_idma_rsp_ready_i;
  idma_req_t       backend_idma_req_o;
  logic            backend_idma_req_valid_o;
  logic            backend_idma_req_ready_i;
  logic            backend_idma_rsp_valid_i;
  logic            backend_idma_rsp_ready_o;
  axis_large_req_t axis_in_req_i;
  axis_large_rsp_t axis_in_rsp_o;
  axis_large_req_t axis_out_req_o;
  axis_large_rsp_t axis_out_rsp_i;

  // slave: the midend itself; master: the surrounding frontend/backend/PJDL TX.
  modport slave (
    input  frontend_idma_req_i, frontend_idma_req_valid_i, frontend_idma_rsp_ready_i,
    input  backend_idma_req_ready_i, backend_idma_rsp_valid_i, axis_in_req_i, axis_out_rsp_i,
    output frontend_idma_req_ready_o, frontend_idma_rsp_valid_o, backend_idma_req_o,
    output backend_idma_req_valid_o, backend_idma_rsp_ready_o, axis_in_rsp_o, axis_out_req_o
  );

  modport master (
    output frontend_idma_req_i, frontend_idma_req_valid_i, frontend_idma_rsp_ready_i,
    output backend_idma_req_ready_i, backend_idma_rsp_valid_i, axis_in_req_i, axis_out_rsp_i,
    input  frontend_idma_req_ready_o, frontend_idma_rsp_valid_o, backend_idma_req_o,
    input  backend_idma_req_valid_o, backend_idma_rsp_ready_o, axis_in_rsp_o, axis_out_req_o
  );

endinterface
`default_nettype wire

// File: rtl/pjdl_idma_tx_midend.sv
// pjdl_idma_tx_midend: splits stream-destined iDMA requests into chunks and injects tlast. Rev 1.0
// Optional abort input enabled by defining PJDL_TX_MIDEND_ABORT_EN.
`default_nettype none
module pjdl_idma_tx_midend
  import pjdl_pkg::*;
#(
  parameter logic [31:0] axis_address = 32'h0000_0000,
  parameter int unsigned ChunkBytes   = PjdlChunkBytes
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  pjdl_idma_tx_midend_if.slave        bus,
`ifdef PJDL_TX_MIDEND_ABORT_EN
  input  logic                        abort_i,
`endif
  output logic                        busy_o
);

  localparam logic [31:0] ChunkLen = 32'(ChunkBytes);

  pjdl_tx_midend_state_e state_q;
  idma_req_t             req_q;
  idma_req_t             fe_stream_req;
  idma_req_t             next_req;
  logic                  last_chunk_q;
  logic                  last_now;

  function automatic idma_req_t chunk_of(input idma_req_t r);
    idma_req_t c;
    c        = r;
    c.length = chunk_len(r.length, ChunkLen);
    return c;
  endfunction

  always_comb begin
    fe_stream_req                  = bus.frontend_idma_req_i;
    fe_stream_req.opt.dst_protocol = AXI_STREAM;
    next_req                       = req_q;
    next_req.length                = req_q.length - ChunkLen;
    next_req.src_addr              = req_q.src_addr + ChunkLen;
  end

`ifdef PJDL_TX_MIDEND_ABORT_EN
  assign last_now = last_chunk_q | abort_i;
`else
  assign last_now = last_chunk_q;
`endif

  // req_q doubles as the running length/source of a stream transfer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q                       <= IDLE;
      req_q                         <= '0;
      last_chunk_q                  <= 1'b0;
      busy_o                        <= 1'b0;
      bus.frontend_idma_req_ready_o <= 1'b1;
      bus.frontend_idma_rsp_valid_o <= 1'b0;
      bus.backend_idma_req_o        <= '0;
      bus.backend_idma_req_valid_o  <= 1'b0;
      bus.backend_idma_rsp_ready_o  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.frontend_idma_req_valid_i) begin
            bus.frontend_idma_req_ready_o <= 1'b0;
            busy_o                        <= 1'b1;
            if (bus.frontend_idma_req_i.dst_addr == axis_address) begin
              req_q        <= fe_stream_req;
              last_chunk_q <= (fe_stream_req.length <= ChunkLen);
              if (fe_stream_req.length == '0) begin
                state_q                       <= RESP;
                bus.frontend_idma_rsp_valid_o <= 1'b1;
              end else begin
                state_q                      <= S_ISSUE;
                bus.backend_idma_req_valid_o <= 1'b1;
                bus.backend_idma_req_o       <= chunk_of(fe_stream_req);
              end
            end else begin
              req_q                        <= bus.frontend_idma_req_i;
              state_q                      <= P_ISSUE;
              bus.backend_idma_req_valid_o <= 1'b1;
              bus.backend_idma_req_o       <= bus.frontend_idma_req_i;
            end
          end
        end
        S_ISSUE: begin
`ifdef PJDL_TX_MIDEND_ABORT_EN
          if (abort_i) begin
            last_chunk_q <= 1'b1;
            req_q.length <= chunk_len(req_q.length, ChunkLen);
          end
`endif
          if (bus.backend_idma_req_ready_i) begin
            bus.backend_idma_req_valid_o <= 1'b0;
            bus.backend_idma_rsp_ready_o <= 1'b1;
            state_q                      <= S_WAIT;
          end
        end
        S_WAIT: begin
`ifdef PJDL_TX_MIDEND_ABORT_EN
          if (abort_i) last_chunk_q <= 1'b1;
`endif
          if (bus.backend_idma_rsp_valid_i) begin
            bus.backend_idma_rsp_ready_o <= 1'b0;
            if (last_now) begin
              state_q                       <= RESP;
              bus.frontend_idma_rsp_valid_o <= 1'b1;
            end else begin
              req_q                        <= next_req;
              last_chunk_q                 <= (next_req.length <= ChunkLen);
              bus.backend_idma_req_valid_o <= 1'b1;
              bus.backend_idma_req_o       <= chunk_of(next_req);
              state_q                      <= S_ISSUE;
            end
          end
        end
        P_ISSUE: begin
          if (bus.backend_idma_req_ready_i) begin
            bus.backend_idma_req_valid_o <= 1'b0;
            bus.backend_idma_rsp_ready_o <= 1'b1;
            state_q                      <= P_WAIT;
          end
        end
        P_WAIT: begin
          if (bus.backend_idma_rsp_valid_i) begin
            bus.backend_idma_rsp_ready_o  <= 1'b0;
            bus.frontend_idma_rsp_valid_o <= 1'b1;
            state_q                       <= RESP;
          end
        end
        RESP: begin
          if (bus.frontend_idma_rsp_ready_i) begin
            bus.frontend_idma_rsp_valid_o <= 1'b0;
            bus.frontend_idma_req_ready_o <= 1'b1;
            busy_o                        <= 1'b0;
            last_chunk_q                  <= 1'b0;
            state_q                       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.axis_out_req_o        = bus.axis_in_req_i;
    bus.axis_out_req_o.t.last = bus.axis_in_req_i.t.last |
                                (((state_q == S_ISSUE) || (state_q == S_WAIT)) & last_chunk_q);
    bus.axis_in_rsp_o.tready  = bus.axis_out_rsp_i.tready;
  end

endmodule
`default_nettype wire

// File: tb/tb_pjdl_idma_tx_midend.sv
// tb_pjdl_idma_tx_midend: vector-table bench for the PJDL TX midend. Rev 1.0
`default_nettype none
module tb_pjdl_idma_tx_midend;
  import pjdl_pkg::*;

  localparam logic [31:0] AXIS = 32'h4000_0000;

  typedef struct packed {
    logic [31:0]      src;
    logic [31:0]      dst;
    logic [31:0]      len;
    logic [7:0]       n;
    logic             stream;
    logic [7:0]       bk_delay;
    logic [7:0]       rsp_delay;
    logic [7:0]       abort_chunk;
    logic [2:0][31:0] exp_len;
    logic [2:0][31:0] exp_src;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[10];
  int   nvec = 0;

  always #5 clk = ~clk;

  pjdl_idma_tx_midend_if bus ();

  pjdl_idma_tx_midend #(.axis_address(AXIS), .ChunkBytes(4)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave),
`ifdef PJDL_TX_MIDEND_ABORT_EN
    .abort_i(abort),
`endif
    .busy_o (busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] src, dst, len, input int n, input logic stream,
                              input int bkd, rsd, ab, input logic [31:0] l0, l1, l2, s0, s1, s2);
    vec_t v;
    v.src = src; v.dst = dst; v.len = len; v.n = 8'(n); v.stream = stream;
    v.bk_delay = 8'(bkd); v.rsp_delay = 8'(rsd); v.abort_chunk = 8'(ab);
    v.exp_len[0] = l0; v.exp_len[1] = l1; v.exp_len[2] = l2;
    v.exp_src[0] = s0; v.exp_src[1] = s1; v.exp_src[2] = s2;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.frontend_idma_req_i       = '0;
    bus.frontend_idma_req_valid_i = 1'b0;
    bus.frontend_idma_rsp_ready_i = 1'b0;
    bus.backend_idma_req_ready_i  = 1'b0;
    bus.backend_idma_rsp_valid_i  = 1'b0;
    bus.axis_in_req_i             = '0;
    bus.axis_out_rsp_i            = '0;
  endtask

  task automatic run_vec(input vec_t v);
    idma_req_t req;
    idma_req_t exp;
    int        w;
    @(negedge clk);
    req = '0;
    req.src_addr = v.src;
    req.dst_addr = v.dst;
    req.length   = v.len;
    req.opt.src_protocol = AXI;
    req.opt.dst_protocol = AXI;
    bus.frontend_idma_req_i       = req;
    bus.frontend_idma_req_valid_i = 1'b1;
    check("fe_req_ready_idle", bus.frontend_idma_req_ready_o, 1);
    @(negedge clk);
    bus.frontend_idma_req_valid_i = 1'b0;
    bus.frontend_idma_req_i       = '0;
    check("busy_after_accept", busy, 1);
    check("fe_req_ready_busy", bus.frontend_idma_req_ready_o, 0);
    if (v.n == 0) check("zero_len_no_bk_valid", bus.backend_idma_req_valid_o, 0);
    for (int k = 0; k < int'(v.n); k++) begin
      w = 0;
      while (!bus.backend_idma_req_valid_o && w < 20) begin
        @(negedge clk);
        w++;
      end
      check("bk_valid_latency", w, 0);
      if (w == 20) return;
      exp = req;
      if (v.stream) begin
        exp.length           = v.exp_len[k];
        exp.src_addr         = v.exp_src[k];
        exp.opt.dst_protocol = AXI_STREAM;
      end
      check("bk_req", bus.backend_idma_req_o, exp);
      check("bk_rsp_ready_issue", bus.backend_idma_rsp_ready_o, 0);
      for (int d = 0; d < int'(v.bk_delay); d++) begin
        @(negedge clk);
        check("bk_valid_hold", bus.backend_idma_req_valid_o, 1);
        check("bk_req_hold", bus.backend_idma_req_o, exp);
      end
      bus.backend_idma_req_ready_i = 1'b1;
      @(negedge clk);
      bus.backend_idma_req_ready_i = 1'b0;
      check("bk_valid_drop", bus.backend_idma_req_valid_o, 0);
      check("bk_rsp_ready_wait", bus.backend_idma_rsp_ready_o, 1);
      if (int'(v.abort_chunk) == k + 1) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
      bus.axis_in_req_i.tvalid  = 1'b1;
      bus.axis_in_req_i.t.data  = 32'hA5A5_0000 | 32'(k);
      bus.axis_in_req_i.t.strb  = 4'hF;
      bus.axis_in_req_i.t.last  = 1'b0;
      bus.axis_out_rsp_i.tready = k[0];
      #1;
      check("beat_tlast", bus.axis_out_req_o.t.last, (v.stream && k == int'(v.n) - 1));
      check("beat_data", bus.axis_out_req_o.t.data, 32'hA5A5_0000 | 32'(k));
      check("beat_tready", bus.axis_in_rsp_o.tready, k[0]);
      bus.axis_in_req_i  = '0;
      bus.axis_out_rsp_i = '0;
      bus.backend_idma_rsp_valid_i = 1'b1;
      @(negedge clk);
      bus.backend_idma_rsp_valid_i = 1'b0;
    end
    check("fe_rsp_valid", bus.frontend_idma_rsp_valid_o, 1);
    check("no_extra_bk_req", bus.backend_idma_req_valid_o, 0);
    for (int d = 0; d < int'(v.rsp_delay); d++) begin
      @(negedge clk);
      check("fe_rsp_hold", bus.frontend_idma_rsp_valid_o, 1);
      check("no_dup_bk_req", bus.backend_idma_req_valid_o, 0);
    end
    bus.frontend_idma_rsp_ready_i = 1'b1;
    @(negedge clk);
    bus.frontend_idma_rsp_ready_i = 1'b0;
    check("fe_rsp_drop", bus.frontend_idma_rsp_valid_o, 0);
    check("fe_req_ready_back", bus.frontend_idma_req_ready_o, 1);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst_fe_req_ready", bus.frontend_idma_req_ready_o, 1);
    check("rst_bk_valid", bus.backend_idma_req_valid_o, 0);
    check("rst_bk_rsp_ready", bus.backend_idma_rsp_ready_o, 0);
    check("rst_fe_rsp_valid", bus.frontend_idma_rsp_valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_bk_req", bus.backend_idma_req_o, 0);
    rst_n = 1'b1;

    vecs[nvec] = mk(32'h1000_0000, AXIS, 10, 3, 1, 0, 0, 0, 4, 4, 2,
                    32'h1000_0000, 32'h1000_0004, 32'h1000_0008); nvec++;
    vecs[nvec] = mk(32'h1000_0040, AXIS, 4, 1, 1, 0, 0, 0, 4, 0, 0,
                    32'h1000_0040, 0, 0); nvec++;
    vecs[nvec] = mk(32'h2000_0000, 32'h1000_2000, 64, 1, 0, 0, 0, 0, 64, 0, 0,
                    32'h2000_0000, 0, 0); nvec++;
    vecs[nvec] = mk(32'h1000_0080, AXIS, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); nvec++;
    vecs[nvec] = mk(32'h3000_0000, AXIS, 6, 2, 1, 5, 3, 0, 4, 2, 0,
                    32'h3000_0000, 32'h3000_0004, 0); nvec++;
    vecs[nvec] = mk(32'h3000_0100, AXIS, 5, 2, 1, 0, 0, 0, 4, 1, 0,
                    32'h3000_0100, 32'h3000_0104, 0); nvec++;
    vecs[nvec] = mk(32'h3000_0200, AXIS, 8, 2, 1, 1, 1, 0, 4, 4, 0,
                    32'h3000_0200, 32'h3000_0204, 0); nvec++;
    vecs[nvec] = mk(32'h5000_0000, 32'h1000_3000, 3, 1, 0, 5, 3, 0, 3, 0, 0,
                    32'h5000_0000, 0, 0); nvec++;
`ifdef PJDL_TX_MIDEND_ABORT_EN
    vecs[nvec] = mk(32'h1000_0100, AXIS, 12, 2, 1, 0, 0, 2, 4, 4, 0,
                    32'h1000_0100, 32'h1000_0104, 0); nvec++;
`endif
    for (int i = 0; i < nvec; i++) run_vec(vecs[i]);

    // Reset while a stream chunk is outstanding: back to IDLE, beat not terminated.
    @(negedge clk);
    bus.frontend_idma_req_i.src_addr = 32'h6000_0000;
    bus.frontend_idma_req_i.dst_addr = AXIS;
    bus.frontend_idma_req_i.length   = 32'd10;
    bus.frontend_idma_req_valid_i    = 1'b1;
    @(negedge clk);
    bus.frontend_idma_req_valid_i = 1'b0;
    bus.backend_idma_req_ready_i  = 1'b1;
    @(negedge clk);
    bus.backend_idma_req_ready_i = 1'b0;
    check("midrst_wait_state", bus.backend_idma_rsp_ready_o, 1);
    rst_n = 1'b0;
    bus.axis_in_req_i.tvalid = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_fe_ready", bus.frontend_idma_req_ready_o, 1);
    check("midrst_bk_rsp_ready", bus.backend_idma_rsp_ready_o, 0);
    check("midrst_bk_req", bus.backend_idma_req_o, 0);
    check("midrst_no_tlast", bus.axis_out_req_o.t.last, 0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
